// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline-stage constants, MW bundle field layout and occupancy encoding.
package pipe_pkg;
    localparam int MW_W      = 165;
    localparam int INSTR_LSB = 133;
    localparam int ALU_LSB   = 101;
    localparam int DM_LSB    = 69;
    localparam int EXT_LSB   = 37;
    localparam int PC8_LSB   = 5;
    localparam int WBA_LSB   = 0;
    localparam logic [31:0] NOP_INSTR = 32'h0;
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_BUSY  = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;
endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic valid/ready pipeline stage with flush and optional 2-entry skid buffer.
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   flush           : empties the stage at the next edge
//   in_valid/ready  : upstream handshake, in_data payload
//   out_valid/ready : downstream handshake, out_data head payload (zero when empty)
//   occupancy       : entries held, 0..2
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = MW_W,
    parameter bit SKID  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);
    if (SKID) begin : g_skid
        occ_e             state_q, state_d;
        logic [WIDTH-1:0] head_q, head_d, skid_q, skid_d;
        logic             ready_q, accept, consume;
        // in_ready comes straight from a flop so there is no in->out combinational path
        assign in_ready  = ready_q;
        assign out_valid = state_q != OCC_EMPTY;
        assign out_data  = head_q;
        assign occupancy = state_q;
        assign accept    = in_valid & ready_q;
        assign consume   = out_valid & out_ready;
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= OCC_EMPTY;
                head_q  <= '0;
                skid_q  <= '0;
                ready_q <= 1'b1;
            end else begin
                state_q <= state_d;
                head_q  <= head_d;
                skid_q  <= skid_d;
                ready_q <= state_d != OCC_FULL;
            end
        end
        always_comb begin
            state_d = state_q;
            head_d  = head_q;
            skid_d  = skid_q;
            if (flush) begin
                state_d = OCC_EMPTY;
                head_d  = '0;
                skid_d  = '0;
            end else begin
                case (state_q)
                    OCC_EMPTY: if (accept) begin
                        state_d = OCC_BUSY;
                        head_d  = in_data;
                    end
                    OCC_BUSY: if (accept && consume) begin
                        head_d = in_data;
                    end else if (accept) begin
                        state_d = OCC_FULL;
                        skid_d  = in_data;
                    end else if (consume) begin
                        state_d = OCC_EMPTY;
                        head_d  = '0;
                    end
                    OCC_FULL: if (consume) begin
                        state_d = OCC_BUSY;
                        head_d  = skid_q;
                        skid_d  = '0;
                    end
                    default: begin
                        state_d = OCC_EMPTY;
                        head_d  = '0;
                        skid_d  = '0;
                    end
                endcase
            end
        end
    end else begin : g_flat
        logic             valid_q, valid_d, accept, consume;
        logic [WIDTH-1:0] data_q, data_d;
        assign in_ready  = out_ready | ~valid_q;
        assign out_valid = valid_q;
        assign out_data  = data_q;
        assign occupancy = {1'b0, valid_q};
        assign accept    = in_valid & in_ready;
        assign consume   = valid_q & out_ready;
        always_ff @(posedge clk) begin
            if (reset) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end
        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            if (flush || (consume && !accept)) begin
                valid_d = 1'b0;
                data_d  = '0;
            end else if (accept) begin
                valid_d = 1'b1;
                data_d  = in_data;
            end
        end
    end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic, parametrised pipeline stage register for the 5-stage MIPS core. It replaces the fixed per-stage latches (FD/DE/EM/MW) with a single block that has a valid/ready handshake, a synchronous flush (bubble insert), stall by back-pressure and an optional 2-entry skid buffer. It sits between any two adjacent stages; the payload is the packed field bundle of that stage.

Parameters:
WIDTH, 165, payload width in bits (default = MW bundle: Instr, ALU, DM, EXT, PC8 at 32 bits each, plus WBA at 5 bits)
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous: empties the stage (bubble) at the next edge
in_valid  input  1  upstream offers in_data
in_ready  output  1  stage can accept this cycle
in_data  input  WIDTH  upstream payload
out_valid  output  1  out_data holds a valid entry
out_ready  input  1  downstream consumes out_data this cycle
out_data  output  WIDTH  head payload; all-zero when out_valid=0 (zero Instr = nop)
occupancy  output  2  entries held: 0..2 (max 1 when SKID=0)

Behaviour:
- Clock and reset: clk, rising edge. reset is synchronous, active-high.
- Reset state: out_valid=0, out_data=0, skid entry empty with payload 0, occupancy=0. in_ready=1 in the first cycle after reset.
- Priority at each edge: reset > flush > normal operation.
- Transfer rules: accept = in_valid & in_ready; consume = out_valid & out_ready. Latency = 1 cycle from accept to out_valid when the stage is empty.
- Flush: next edge sets all valids to 0, all payload to 0, occupancy to 0.
  - Data offered or accepted in the flush cycle is discarded.
  - A consume in the flush cycle still counts as taken by downstream.
- Zero-payload invariant: out_data == 0 whenever out_valid == 0. Payload is zeroed on every transition to empty.

SKID=0:
- in_ready = out_ready | ~out_valid (combinational).
- accept: out_data <= in_data, out_valid <= 1.
- consume without accept: out_valid <= 0, out_data <= 0.
- Neither: hold (stall).

SKID=1 (in_ready = ~skid_valid, driven from a register; no combinational in->out path):
- EMPTY (occ 0):
  - accept -> BUSY, head <= in_data.
- BUSY (occ 1):
  - accept & consume -> BUSY, head <= in_data.
  - accept & ~consume -> FULL, skid <= in_data.
  - ~accept & consume -> EMPTY, head <= 0.
  - else hold.
- FULL (occ 2), in_ready=0:
  - consume -> BUSY, head <= skid, skid <= 0.
  - else hold.
- Ordering: strict FIFO order, no duplication or loss except on flush or reset.
- in_valid while in_ready=0: ignored. Upstream must hold its data; the block does not check this.
- Reset or flush asserted mid-stall in FULL: the stage empties and both entries are lost.

Decomposition:
- Shared package pipe_pkg:
  - MW field offsets/widths as localparams: INSTR_LSB=133, ALU_LSB=101, DM_LSB=69, EXT_LSB=37, PC8_LSB=5, WBA_LSB=0, MW_W=165.
  - NOP_INSTR=32'h0.
  - Occupancy encoding: OCC_EMPTY=0, OCC_BUSY=1, OCC_FULL=2.
- No sub-module needed. The skid entry is an internal register inside a generate branch on SKID.

Test Plan:
1. Reset then idle: out_valid=0, out_data=0, occupancy=0, in_ready=1, for both SKID values.
2. Stream (SKID=1), out_ready=1: push A=0x1, B=0x2, C=0x3 on consecutive cycles -> out_data shows 0x1, 0x2, 0x3 one cycle later each; occupancy stays 1.
3. Back-pressure (SKID=1):
   - Push 0xA with out_ready=0, then push 0xB -> occupancy=2, in_ready=0.
   - Push 0xC is ignored.
   - Raise out_ready -> outputs 0xA then 0xB; 0xC is never seen.
4. Flush in FULL with in_valid=1 carrying 0xD -> next cycle out_valid=0, out_data=0, occupancy=0, in_ready=1; 0xD is dropped.
5. SKID=0, out_valid=1 holding 0x5, out_ready=1, in_valid=1 with 0x6 in the same cycle -> in_ready=1 and next out_data=0x6; with out_ready=0 -> in_ready=0 and 0x5 is held.
6. Reset asserted together with flush and in_valid=1 (0x7) -> all outputs 0, nothing accepted; next cycle in_ready=1.
